bcd_down_counter: RTL and testbench
===================================

Name: bcd_down_counter

Overview:
- Multi-digit BCD down-counter/timer. It counts in the opposite direction to the team's mod-10 up-counter, with a borrow-out in place of carry-out.
- Digits load in parallel, decrement on enable, and signal terminal count with a one-cycle borrow pulse.
- Optional auto-reload makes it a periodic tick generator.
- Sits beside the up-counter in the timing/control subsystem. Its bout can drive the up-counter's enable.

Parameters:
- DIGITS, 4, number of BCD digits; counter width is 4*DIGITS.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- load  input  1  parallel load strobe
- load_val  input  4*DIGITS  BCD value to load (digit 0 = bits 3:0)
- start  input  1  begin counting
- stop  input  1  pause counting
- en  input  1  count step qualifier
- reload_en  input  1  auto-reload on terminal count
- cnt  output  4*DIGITS  current BCD count, registered
- bout  output  1  borrow-out pulse at terminal count, registered
- done  output  1  expired flag, level
- zero  output  1  cnt == 0, combinational from cnt
- load_err  output  1  illegal-BCD load pulse, registered

Behaviour:
- Reset (async, rstn=0):
  - cnt=0, bout=0, done=0, load_err=0; zero=1.
  - Internal reload register=0, state=IDLE.
  - Reset mid-RUN aborts immediately with the same values.
- FSM states: IDLE, RUN, EXPIRED.
- Per-cycle priority: load > stop > start > en step.
- load (any state):
  - If every digit of load_val is ≤ 9: cnt and reload register capture load_val; state becomes IDLE; done cleared.
  - Otherwise: cnt, reload register and state are unchanged; load_err=1 for exactly one cycle.
- IDLE:
  - cnt holds.
  - start with cnt≠0 goes to RUN.
  - start with cnt==0 is ignored and stays in IDLE.
- RUN:
  - stop goes to IDLE; cnt holds.
  - en=0: cnt holds.
  - en=1 and cnt>1: BCD decrement by 1. Digit 0 becoming 9 borrows from the next digit (e.g. 0100 → 0099).
  - en=1 and cnt==1 (terminal step):
    - bout=1 for that one cycle (registered, coincident with the new cnt).
    - reload_en=1: cnt takes the reload register value and the state stays RUN, giving a period of exactly N enabled steps.
    - reload_en=0: cnt becomes 0, done=1, state goes to EXPIRED.
- EXPIRED:
  - cnt=0 and done=1 hold.
  - start returns to IDLE and clears done; cnt stays 0.
  - load behaves as above.
- Simultaneous events:
  - load with start: load wins; state IDLE, start is dropped.
  - stop with a terminal step: stop wins; no bout, cnt holds at 1.
  - reload_en is sampled only on the terminal step.
- bout is never asserted outside the terminal step. Back-to-back bout pulses are possible only with reload value 1 and continuous en.
- No wrap below zero is possible; RUN is never entered with cnt==0.

Test Plan:
- Reset: rstn=0 mid-RUN with cnt=0042 → cnt=0000, zero=1, done=0, bout=0 at once, without waiting for a clock edge.
- Basic count (DIGITS=4):
  - Stimulus: load 0x0012, then start, en=1 continuous.
  - Response: cnt 0011, 0010, 0009 … 0001, 0000 over 12 cycles.
  - bout=1 only in the cycle cnt=0000 appears; then done=1, EXPIRED holds.
- Auto-reload:
  - Stimulus: load 0x0003, reload_en=1, start, en=1.
  - Response: cnt 3,2,1,3,2,1,3…; bout pulses on each 1→3 transition, every 3 cycles; done stays 0.
- Digit borrow with gaps:
  - Stimulus: load 0x1000, start, en toggling 1/0.
  - Response: 1000 → 0999 on the first enabled edge; cnt holds on en=0 cycles; stop freezes cnt and state goes to IDLE.
- Illegal load: load 0x00A5 while cnt=0007 → load_err=1 for one cycle, cnt stays 0007, state unchanged.
- Collisions:
  - load 0x0020 with start in the same cycle → cnt=0020, state IDLE, not counting.
  - stop asserted on the cycle cnt==1 with en=1 → cnt stays 0001, no bout.

Source files
------------

// File: rtl/bcd_down_counter.sv
// -----------------------------------------------------------------------------
// bcd_down_counter
//
// Multi-digit BCD down-counter / timer. A value is loaded in parallel, counting
// is started and paused with start/stop, and each cycle with en=1 while running
// steps the count down by one in BCD. The step from 1 is the terminal step. On
// that step bout pulses for one cycle. The counter then either reloads the last
// loaded value (reload_en=1, periodic tick) or stops at zero and raises done.
//
// Parameters
//   DIGITS     number of BCD digits; data width is 4*DIGITS
//
// Ports
//   clk        clock
//   rstn       asynchronous active-low reset
//   load       parallel load strobe (highest priority)
//   load_val   BCD value to load, digit 0 in bits [3:0]
//   start      start counting (IDLE) / acknowledge expiry (EXPIRED)
//   stop       pause counting (RUN -> IDLE)
//   en         count step qualifier while running
//   reload_en  reload instead of expiring on the terminal step
//   cnt        current BCD count (registered)
//   bout       borrow-out pulse on the terminal step (registered)
//   done       expired flag (registered level)
//   zero       cnt == 0 (combinational from cnt)
//   load_err   one-cycle pulse when a load carries a non-BCD digit (registered)
// -----------------------------------------------------------------------------
module bcd_down_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  en,
    input  logic                  reload_en,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  bout,
    output logic                  done,
    output logic                  zero,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    // Registered state and outputs.
    state_t          state_q;
    state_t          state_d;
    logic [W-1:0]    cnt_q;
    logic [W-1:0]    cnt_d;
    logic [W-1:0]    reload_q;
    logic [W-1:0]    reload_d;
    logic            bout_q;
    logic            bout_d;
    logic            done_q;
    logic            done_d;
    logic            load_err_q;
    logic            load_err_d;

    // A value is legal BCD when no digit exceeds 9.
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // BCD decrement by one. A digit at 0 becomes 9 and the borrow ripples
    // upward until a non-zero digit absorbs it. Callers never pass zero.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        logic [3:0]   d;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    // Next-state logic, with priority load > stop > start > en step.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reload_d   = reload_q;
        done_d     = done_q;
        bout_d     = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            if (bcd_valid(load_val)) begin
                cnt_d    = load_val;
                reload_d = load_val;
                state_d  = ST_IDLE;
                done_d   = 1'b0;
            end else begin
                // Rejected load: everything holds, only the error pulse fires.
                load_err_d = 1'b1;
            end
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end else begin
                state_d = state_q;
            end
        end else if (start) begin
            case (state_q)
                ST_IDLE: begin
                    // Never enter RUN at zero, so the counter cannot wrap.
                    if (cnt_q != CNT_ZERO) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
                default: begin
                    // start while already running consumes the cycle
                    state_d = state_q;
                end
            endcase
        end else if ((state_q == ST_RUN) && en) begin
            if (cnt_q == CNT_ONE) begin
                // Terminal step: reload_en is only looked at here.
                bout_d = 1'b1;
                if (reload_en) begin
                    cnt_d   = reload_q;
                    state_d = ST_RUN;
                end else begin
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b1;
                    state_d = ST_EXPIRED;
                end
            end else begin
                cnt_d = bcd_dec(cnt_q);
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            reload_q   <= CNT_ZERO;
            bout_q     <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            bout_q     <= bout_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign cnt      = cnt_q;
    assign bout     = bout_q;
    assign done     = done_q;
    assign load_err = load_err_q;
    assign zero     = (cnt_q == CNT_ZERO);

endmodule

// File: tb/tb_bcd_down_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_down_counter
//
// Directed bench for bcd_down_counter (DIGITS=4). A reference model keeps the
// count as a plain integer with a named mode, updated once per clock edge from
// the same inputs the DUT sees. A single negedge process compares every output
// against the model. Literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_bcd_down_counter;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXP  = 2;

    logic          clk;
    logic          rstn;
    logic          load;
    logic [W-1:0]  load_val;
    logic          start;
    logic          stop;
    logic          en;
    logic          reload_en;
    logic [W-1:0]  cnt;
    logic          bout;
    logic          done;
    logic          zero;
    logic          load_err;

    int checks;
    int errors;
    bit chk_en;

    // Reference model state.
    int m_cnt;
    int m_rel;
    int m_mode;
    bit m_done;
    bit m_bout;
    bit m_err;

    bcd_down_counter #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .reload_en (reload_en),
        .cnt       (cnt),
        .bout      (bout),
        .done      (done),
        .zero      (zero),
        .load_err  (load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t           = t / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            r = r * 10 + int'(v[4*i +: 4]);
        end
        return r;
    endfunction

    function automatic bit is_bcd(input logic [W-1:0] v);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_rel  = 0;
        m_mode = M_IDLE;
        m_done = 1'b0;
        m_bout = 1'b0;
        m_err  = 1'b0;
    endtask

    // One clock edge of the model, driven from the rules in plain arithmetic.
    task automatic model_step();
        if (!rstn) begin
            model_reset();
        end else begin
            m_bout = 1'b0;
            m_err  = 1'b0;
            if (load) begin
                if (is_bcd(load_val)) begin
                    m_cnt  = from_bcd(load_val);
                    m_rel  = m_cnt;
                    m_mode = M_IDLE;
                    m_done = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end else if (stop) begin
                if (m_mode == M_RUN) m_mode = M_IDLE;
            end else if (start) begin
                if (m_mode == M_IDLE && m_cnt != 0) begin
                    m_mode = M_RUN;
                end else if (m_mode == M_EXP) begin
                    m_mode = M_IDLE;
                    m_done = 1'b0;
                end
            end else if (m_mode == M_RUN && en) begin
                if (m_cnt == 1) begin
                    m_bout = 1'b1;
                    if (reload_en) begin
                        m_cnt = m_rel;
                    end else begin
                        m_cnt  = 0;
                        m_done = 1'b1;
                        m_mode = M_EXP;
                    end
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_cnt",      32'(cnt),      32'(to_bcd(m_cnt)));
            chk("model_bout",     32'(bout),     32'(m_bout));
            chk("model_done",     32'(done),     32'(m_done));
            chk("model_zero",     32'(zero),     32'(m_cnt == 0));
            chk("model_load_err", 32'(load_err), 32'(m_err));
        end
    end

    // Apply inputs, then let one clock edge pass and advance the model.
    task automatic tick(input logic l, input logic [W-1:0] lv, input logic s,
                        input logic p, input logic e);
        load     = l;
        load_val = lv;
        start    = s;
        stop     = p;
        en       = e;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle_tick();
        tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic en_tick();
        tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic load_tick(input logic [W-1:0] lv);
        tick(1'b1, lv, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_tick();
        tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        chk_en    = 1'b0;
        rstn      = 1'b0;
        load      = 1'b0;
        load_val  = 16'h0000;
        start     = 1'b0;
        stop      = 1'b0;
        en        = 1'b0;
        reload_en = 1'b0;
        model_reset();
        #2;
        chk("reset_cnt",      32'(cnt),      32'h0);
        chk("reset_zero",     32'(zero),     32'h1);
        chk("reset_done",     32'(done),     32'h0);
        chk("reset_bout",     32'(bout),     32'h0);
        chk("reset_load_err", 32'(load_err), 32'h0);
        chk_en = 1'b1;
        idle_tick();
        rstn = 1'b1;
        idle_tick();

        // Basic count from 12 down to expiry.
        load_tick(16'h0012);
        start_tick();
        for (int i = 0; i < 3; i++) en_tick();
        chk("basic_after3", 32'(cnt), 32'h0009);
        for (int i = 0; i < 9; i++) en_tick();
        chk("basic_term_cnt",  32'(cnt),  32'h0000);
        chk("basic_term_bout", 32'(bout), 32'h1);
        chk("basic_term_done", 32'(done), 32'h1);
        en_tick();
        en_tick();
        chk("expired_bout", 32'(bout), 32'h0);
        chk("expired_done", 32'(done), 32'h1);
        start_tick();
        chk("expired_start_done", 32'(done), 32'h0);

        // Auto-reload periodic tick with period 3.
        reload_en = 1'b1;
        load_tick(16'h0003);
        start_tick();
        for (int i = 0; i < 3; i++) en_tick();
        chk("reload_cnt",  32'(cnt),  32'h0003);
        chk("reload_bout", 32'(bout), 32'h1);
        for (int i = 0; i < 6; i++) en_tick();
        chk("reload_done", 32'(done), 32'h0);
        tick(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        reload_en = 1'b0;

        // Multi-digit borrow with en gaps, then stop.
        load_tick(16'h1000);
        start_tick();
        en_tick();
        chk("borrow_first", 32'(cnt), 32'h0999);
        idle_tick();
        chk("borrow_gap", 32'(cnt), 32'h0999);
        en_tick();
        idle_tick();
        tick(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        en_tick();
        en_tick();
        chk("borrow_stopped", 32'(cnt), 32'h0998);

        // Illegal load while running at 7.
        load_tick(16'h0007);
        start_tick();
        idle_tick();
        load_tick(16'h00A5);
        chk("illegal_err", 32'(load_err), 32'h1);
        chk("illegal_cnt", 32'(cnt),      32'h0007);
        idle_tick();
        chk("illegal_err_clear", 32'(load_err), 32'h0);
        en_tick();
        chk("illegal_still_run", 32'(cnt), 32'h0006);

        // Load and start together: load wins, no counting.
        tick(1'b1, 16'h0020, 1'b1, 1'b0, 1'b0);
        en_tick();
        en_tick();
        chk("load_start_cnt", 32'(cnt), 32'h0020);

        // Stop on the terminal step.
        load_tick(16'h0002);
        start_tick();
        en_tick();
        tick(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("stop_term_cnt",  32'(cnt),  32'h0001);
        chk("stop_term_bout", 32'(bout), 32'h0);
        en_tick();
        start_tick();
        en_tick();
        chk("resume_term_bout", 32'(bout), 32'h1);
        chk("resume_term_done", 32'(done), 32'h1);
        load_tick(16'h0005);
        chk("load_in_expired_done", 32'(done), 32'h0);
        chk("load_in_expired_cnt",  32'(cnt),  32'h0005);

        // Reload value 1 gives back-to-back bout pulses.
        reload_en = 1'b1;
        load_tick(16'h0001);
        start_tick();
        for (int i = 0; i < 3; i++) en_tick();
        chk("b2b_bout", 32'(bout), 32'h1);
        chk("b2b_cnt",  32'(cnt),  32'h0001);
        reload_en = 1'b0;

        // Asynchronous reset in the middle of a run at 42.
        load_tick(16'h0042);
        start_tick();
        idle_tick();
        idle_tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("midrun_reset_cnt",  32'(cnt),  32'h0);
        chk("midrun_reset_zero", 32'(zero), 32'h1);
        chk("midrun_reset_done", 32'(done), 32'h0);
        chk("midrun_reset_bout", 32'(bout), 32'h0);
        model_reset();
        idle_tick();
        rstn = 1'b1;
        en_tick();
        start_tick();
        en_tick();
        chk("post_reset_idle", 32'(cnt), 32'h0);

        idle_tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
